// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: oversampled I2C target with a pointer-addressed byte register file
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oen,
  output logic             busy,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [7:0]       wr_byte,
  output logic             stop_det
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE} state_t;
  state_t state;
  logic [2:0] scl_q, sda_q;
  logic scl, sda, scl_rise, scl_fall, sda_rise, sda_fall, start, stop;
  logic [6:0] shreg;
  logic [7:0] rx, rd_data;
  logic [2:0] bit_cnt;
  logic rw, first;
  logic [PTR_W-1:0] ptr;
  logic [7:0] mem [DEPTH];
  assign scl = scl_q[1];
  assign sda = sda_q[1];
  assign scl_rise = scl & ~scl_q[2];
  assign scl_fall = ~scl & scl_q[2];
  assign sda_rise = sda & ~sda_q[2];
  assign sda_fall = ~sda & sda_q[2];
  assign start = sda_fall & scl;
  assign stop = sda_rise & scl;
  assign rx = {shreg, sda};
  assign rd_data = mem[ptr];
  // ACK states use sda_oen itself to tell the driving fall from the releasing fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= '1;
      sda_q <= '1;
      state <= IDLE;
      sda_oen <= 1'b1;
      busy <= 1'b0;
      wr_strobe <= 1'b0;
      wr_ptr <= '0;
      wr_byte <= '0;
      stop_det <= 1'b0;
      shreg <= '0;
      bit_cnt <= '0;
      rw <= 1'b0;
      first <= 1'b1;
      ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
      wr_strobe <= 1'b0;
      stop_det <= 1'b0;
      if (start) begin
        state <= ADDR;
        bit_cnt <= '0;
        sda_oen <= 1'b1;
        busy <= 1'b0;
        first <= 1'b1;
      end else if (stop) begin
        state <= IDLE;
        sda_oen <= 1'b1;
        busy <= 1'b0;
        first <= 1'b1;
        stop_det <= 1'b1;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg <= rx[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx[7:1] == SLAVE_ADDR) begin
                rw <= rx[0];
                busy <= 1'b1;
                state <= ADDR_ACK;
              end else state <= IGNORE;
            end
          end
          ADDR_ACK, WR_ACK: if (scl_fall) begin
            if (sda_oen) sda_oen <= 1'b0;
            else begin
              bit_cnt <= '0;
              if (state == ADDR_ACK && rw) begin
                shreg <= rd_data[6:0];
                sda_oen <= rd_data[7];
                ptr <= ptr + 1'b1;
                state <= RD_BYTE;
              end else begin
                sda_oen <= 1'b1;
                state <= WR_BYTE;
              end
            end
          end
          WR_BYTE: if (scl_rise) begin
            shreg <= rx[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= WR_ACK;
              if (first) begin
                ptr <= rx[PTR_W-1:0];
                first <= 1'b0;
              end else begin
                mem[ptr] <= rx;
                wr_strobe <= 1'b1;
                wr_ptr <= ptr;
                wr_byte <= rx;
                ptr <= ptr + 1'b1;
              end
            end
          end
          RD_BYTE: if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oen <= 1'b1;
              bit_cnt <= '0;
              state <= RD_ACK;
            end else begin
              sda_oen <= shreg[6];
              shreg <= {shreg[5:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          RD_ACK: if (scl_rise) begin
            if (sda) begin
              busy <= 1'b0;
              state <= IGNORE;
            end else bit_cnt <= 3'd1;
          end else if (scl_fall && bit_cnt != 3'd0) begin
            bit_cnt <= '0;
            shreg <= rd_data[6:0];
            sda_oen <= rd_data[7];
            ptr <= ptr + 1'b1;
            state <= RD_BYTE;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: directed bit-banged I2C master against the register-file target
module tb_i2c_slave_regfile;
  localparam int Q = 80;
  logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
  logic sda_oen, busy, wr_strobe, stop_det, sda_line;
  logic [3:0] wr_ptr;
  logic [7:0] wr_byte, d;
  logic a;
  int vecs = 0, errs = 0, stop_cnt = 0, busy_cnt = 0, s0, n, b0;
  logic [11:0] wlog [$];
  assign sda_line = sda_m & sda_oen;
  always #5 clk = ~clk;
  i2c_slave_regfile dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_line), .sda_oen(sda_oen), .busy(busy),
    .wr_strobe(wr_strobe), .wr_ptr(wr_ptr), .wr_byte(wr_byte), .stop_det(stop_det)
  );
  always @(negedge clk) begin
    if (wr_strobe) wlog.push_back({wr_ptr, wr_byte});
    if (stop_det) stop_cnt++;
    if (busy) busy_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic bus_bit(input logic b, output logic r);
    sda_m = b; #Q;
    scl_m = 1'b1; #Q;
    r = sda_line; #Q;
    scl_m = 1'b0; #Q;
  endtask
  task automatic start_c();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask
  task automatic stop_c();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask
  task automatic wbyte(input logic [7:0] v, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(v[i], r);
    bus_bit(1'b1, r);
    ack = ~r;
  endtask
  task automatic rbyte(input logic ack, output logic [7:0] v);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      v[i] = r;
    end
    bus_bit(~ack, r);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end
  initial begin
    #23;
    chk("rst_oen", sda_oen, 1);
    chk("rst_busy", busy, 0);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_stop", stop_det, 0);
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_wr_byte", wr_byte, 0);
    rst = 1'b0; #100;
    // write 0x11,0x22 at 3
    start_c();
    wbyte(8'hA0, a); chk("wr_addr_ack", a, 1);
    chk("wr_busy", busy, 1);
    wbyte(8'h03, a); chk("wr_ptr_ack", a, 1);
    wbyte(8'h11, a); chk("wr_d0_ack", a, 1);
    wbyte(8'h22, a); chk("wr_d1_ack", a, 1);
    stop_c();
    chk("wr_cnt", wlog.size(), 2);
    chk("wr_log0", wlog[0], 12'h311);
    chk("wr_log1", wlog[1], 12'h422);
    chk("wr_stop", stop_cnt, 1);
    chk("wr_busy_end", busy, 0);
    // random read of 3
    start_c();
    wbyte(8'hA0, a);
    wbyte(8'h03, a);
    start_c();
    wbyte(8'hA1, a); chk("rr_addr_ack", a, 1);
    rbyte(1'b0, d); chk("rr_data", d, 8'h11);
    chk("rr_oen_nack", sda_oen, 1);
    chk("rr_busy_nack", busy, 0);
    stop_c();
    start_c();
    wbyte(8'hA1, a);
    rbyte(1'b0, d); chk("rr_ptr4", d, 8'h22);
    stop_c();
    // wrap on write and read
    start_c();
    wbyte(8'hA0, a);
    wbyte(8'h0F, a);
    wbyte(8'hAB, a);
    wbyte(8'hCD, a);
    wbyte(8'h5A, a);
    stop_c();
    chk("wrap_cnt", wlog.size(), 5);
    chk("wrap_log2", wlog[2], 12'hFAB);
    chk("wrap_log3", wlog[3], 12'h0CD);
    chk("wrap_log4", wlog[4], 12'h15A);
    start_c();
    wbyte(8'hA0, a);
    wbyte(8'h0F, a);
    start_c();
    wbyte(8'hA1, a);
    rbyte(1'b1, d); chk("seq_rd0", d, 8'hAB);
    rbyte(1'b0, d); chk("seq_rd1", d, 8'hCD);
    stop_c();
    start_c();
    wbyte(8'hA1, a);
    rbyte(1'b0, d); chk("seq_ptr1", d, 8'h5A);
    stop_c();
    // address mismatch
    b0 = busy_cnt; s0 = stop_cnt; n = wlog.size();
    start_c();
    wbyte(8'hA2, a); chk("mis_addr_nack", a, 0);
    wbyte(8'h55, a); chk("mis_data_nack", a, 0);
    stop_c();
    chk("mis_no_strobe", wlog.size(), n);
    chk("mis_no_busy", busy_cnt, b0);
    chk("mis_stop", stop_cnt, s0 + 1);
    // abort mid-byte leaves reg[5]
    start_c();
    wbyte(8'hA0, a);
    wbyte(8'h05, a);
    wbyte(8'h77, a);
    stop_c();
    s0 = stop_cnt; n = wlog.size();
    start_c();
    wbyte(8'hA0, a);
    wbyte(8'h05, a);
    bus_bit(1'b1, a); bus_bit(1'b1, a); bus_bit(1'b1, a); bus_bit(1'b0, a);
    stop_c();
    chk("abort_no_strobe", wlog.size(), n);
    chk("abort_stop", stop_cnt, s0 + 1);
    start_c();
    wbyte(8'hA0, a);
    wbyte(8'h05, a);
    start_c();
    wbyte(8'hA1, a);
    rbyte(1'b0, d); chk("abort_reg5", d, 8'h77);
    stop_c();
    // reset while driving a 0 data bit (reg[6] is 0)
    start_c();
    wbyte(8'hA1, a); chk("rst_rd_ack", a, 1);
    chk("rst_rd_drive", sda_oen, 0);
    chk("rst_rd_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1; #1;
    chk("async_oen", sda_oen, 1);
    chk("async_busy", busy, 0);
    #20 rst = 1'b0;
    scl_m = 1'b1; sda_m = 1'b1; #(2 * Q);
    start_c();
    wbyte(8'hA1, a); chk("post_rst_ack", a, 1);
    rbyte(1'b0, d); chk("post_rst_data", d, 8'h00);
    stop_c();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- I2C target (slave) with an internal byte register file. It is the responder counterpart of the team's i2c_master and is used as an on-chip EEPROM-style model for closed-loop simulation, and as a configurable register target in FPGA builds.
- It decodes START, repeated START and STOP, matches a 7-bit address, and ACKs.
- First written byte sets a word pointer; later bytes write at the pointer and post-increment it. Reads return bytes from the pointer and post-increment it.
- Oversampled design: SCL/SDA are synchronized into clk; no clock stretching.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit device address compared against address byte [7:1]
DEPTH, 16, register file bytes; power of 2, 2..256
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  system clock; must be >= 16x SCL frequency
rst  input  1  asynchronous, active-high reset
scl_in  input  1  SCL pin level (asynchronous)
sda_in  input  1  SDA pin level (asynchronous)
sda_oen  output  1  SDA output enable, active-low: 0 drives SDA low, 1 releases it
busy  output  1  high from address-matched ACK until STOP/START/abort
wr_strobe  output  1  one-clk pulse when a data byte is written to the register file
wr_ptr  output  PTR_W  register index written; valid with wr_strobe
wr_byte  output  8  data written; valid with wr_strobe
stop_det  output  1  one-clk pulse on every detected STOP

Behaviour:
- Reset (async, immediate): sda_oen=1, busy=0, wr_strobe=0, stop_det=0, wr_ptr=0, wr_byte=0, pointer=0, state=IDLE, register file cleared to 0x00, synchronizers preset to 1.
- Input conditioning: scl_in/sda_in each pass through a 2-FF synchronizer plus 1 history FF.
  - scl_rise/scl_fall and sda_rise/sda_fall are decoded from synchronized level vs history.
- Bus conditions:
  - START = sda_fall while synchronized SCL high. STOP = sda_rise while SCL high.
  - START and STOP take priority over every state, from any state.
  - START -> ADDR, bit counter=0, sda released. This also covers repeated START; the pointer is kept.
  - STOP -> IDLE, sda released, stop_det pulses; no partial-byte write.
- Timing rules:
  - Data is sampled on scl_rise, MSB first.
  - sda_oen changes only on scl_fall, one clk after the synchronized edge.
  - SDA never changes while SCL is high, except release on reset.
- States:
  - IDLE: ignore everything except START.
  - ADDR: shift 8 bits. After the 8th scl_rise:
    - If byte[7:1]==SLAVE_ADDR, latch rw=byte[0] and go to ADDR_ACK.
    - Otherwise go to IGNORE.
  - ADDR_ACK: on next scl_fall, drive 0; hold through the 9th SCL pulse; on the following scl_fall:
    - rw=0: release, go to WR_BYTE.
    - rw=1: drive the MSB of reg[pointer], go to RD_BYTE.
    - busy rises when ADDR_ACK is entered.
  - WR_BYTE: shift 8 bits. After the 8th bit, go to WR_ACK.
    - First data byte after the address phase: pointer = byte[PTR_W-1:0]; upper bits are ignored.
    - Later bytes: reg[pointer]=byte; wr_strobe/wr_ptr/wr_byte updated for one clk on the 8th scl_rise; pointer = pointer+1 mod DEPTH.
    - The "first byte" flag is cleared by START/STOP, not by reset of the pointer.
  - WR_ACK: drive 0 for the 9th clock, release on the following scl_fall, return to WR_BYTE.
  - RD_BYTE: shift out the latched byte; bits 6..0 are driven on successive scl_fall. After the 8th bit's scl_fall, release sda and go to RD_ACK.
    - The pointer post-increments (mod DEPTH) when the byte is latched.
  - RD_ACK: sample SDA on scl_rise.
    - 0 (ACK): on the next scl_fall, latch reg[pointer], drive its MSB, go to RD_BYTE.
    - 1 (NACK): go to IGNORE with sda released.
  - IGNORE: sda released, busy=0; wait for START/STOP.
- Bus release: a 1 data bit in read is driven as release (sda_oen=1), never as a driven high.
- Simultaneous events: if a START/STOP is detected in the same clk as scl_fall, the START/STOP wins.
- Wrap-around: the pointer rolls DEPTH-1 -> 0 on both write and read. There is no end-of-memory NACK.

Test Plan:
- Write: START, 0xA0, 0x03, 0x11, 0x22, STOP -> ACK on all four 9th clocks; reg[3]=0x11, reg[4]=0x22; wr_strobe pulses twice (wr_ptr 3 then 4); stop_det one pulse.
- Random read: after the write test, START, 0xA0, 0x03, repeated START, 0xA1, master NACK, STOP -> slave returns 0x11; sda_oen=1 after NACK; pointer ends at 4.
- Sequential read with wrap: preload reg[15]=0xAB, reg[0]=0xCD; set pointer 0x0F; read 2 bytes (ACK, then NACK) -> 0xAB then 0xCD; pointer=1.
- Address mismatch: START, 0xA2, 0x55, STOP -> 9th clock SDA stays high (NACK); no wr_strobe; busy stays 0; state IDLE after STOP.
- Abort mid-byte: START, 0xA0, 0x05, 4 bits of 0xEE, STOP -> reg[5] unchanged; wr_strobe never fires; stop_det pulses.
- Reset mid-read: assert rst while slave drives a 0 data bit -> sda_oen=1 the same clk (async), busy=0, register file = 0x00; next START/0xA1 read returns 0x00 from pointer 0.
